rsz_row_drain: RTL and testbench
================================

# rsz_row_drain

Receiving end of the resizer's parallel row-forwarding interface (`RSZ_PXL_FWD_SER = 0`, `RSZ_PXL_FWD_TYP = "ROW"`). It accepts resized rows in order, row 0 first, using per-row valid/ready pairs. It latches each row into a one-row buffer and emits the pixels as a single raster-order valid/ready stream carrying row, column and end-of-line/end-of-frame tags. It sits between the resizer output and any serial consumer, such as a DMA writer or a classifier front-end.

## Interface
- `RSZ_IMG_WIDTH_SIZE`, 8: resized image width in pixels. Must be a power of two, ≥ 2.
- `RSZ_IMG_HEIGHT_SIZE`, 8: resized image height in rows. Must be a power of two, ≥ 2.
- `PXL_PRIM_COLOR_NUM`, 1: primary colours per pixel.
- `PXL_PRIM_COLOR_W`, 8: bits per primary colour.
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `fwd_rsz_pxl_i` in `FcRszPxlBuf_t`: full resized-image buffer. Row r is valid while `fwd_rsz_pxl_vld_i[r]` is high.
- `fwd_rsz_pxl_vld_i` in `RSZ_IMG_HEIGHT_SIZE`: per-row valid.
- `fwd_rsz_pxl_rdy_o` out `RSZ_IMG_HEIGHT_SIZE`: per-row ready. At most one bit is high at a time.
- `pxl_o` out `PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W`: output pixel. Colour 0 occupies the LSBs.
- `pxl_vld_o` out 1: output valid.
- `pxl_rdy_i` in 1: output ready from the downstream consumer.
- `pxl_row_o` out `RSZ_IMG_HEIGHT_IDX_W`: row index of `pxl_o`.
- `pxl_col_o` out `RSZ_IMG_WIDTH_IDX_W`: column index of `pxl_o`.
- `pxl_eol_o` out 1: `pxl_o` is the last pixel of its row.
- `pxl_eof_o` out 1: `pxl_o` is the last pixel of the frame.

## Operation
- FSM has two states, `WAIT` and `DRAIN`. Registers: `row_idx`, `col_idx`, row buffer (`FcRszPxlRow_t`).
- `WAIT`:
  - `fwd_rsz_pxl_rdy_o` equals the one-hot of `row_idx`. It is decoded from state registers only, with no combinational path from `fwd_rsz_pxl_vld_i`.
  - On `vld[row_idx] & rdy[row_idx]`, latch row `row_idx` of `fwd_rsz_pxl_i`, clear `col_idx`, and go to `DRAIN`.
- `DRAIN`:
  - `fwd_rsz_pxl_rdy_o` is all-zero. `pxl_vld_o` is 1.
  - `pxl_o` is buffer[`col_idx`]. `pxl_row_o` = `row_idx`, `pxl_col_o` = `col_idx`.
  - `pxl_eol_o` = (`col_idx` == W-1). `pxl_eof_o` = `pxl_eol_o` & (`row_idx` == H-1).
  - On `pxl_vld_o & pxl_rdy_i`:
    - If not at end of line: `col_idx`++.
    - At end of line: `col_idx` goes to 0, `row_idx` goes to (`row_idx` + 1) mod H (wraps to 0 after H-1), and the FSM returns to `WAIT`.
- Upstream contract: `vld[r]` stays high and row r data stays stable until the `rdy[r]` handshake.
- Valid bits for rows other than `row_idx` are ignored and keep waiting; they are never dropped or reordered.
- Backpressure: while `pxl_rdy_i` = 0 in `DRAIN`, all output ports hold their values.
- Pixel data passes through unmodified. There is no arithmetic beyond the index counters, which count modulo W and H.

## Timing
- Reset values: FSM in `WAIT`, `row_idx` = 0, `col_idx` = 0, buffer = 0.
  - Resulting outputs: `fwd_rsz_pxl_rdy_o` = 1 (bit 0 only); `pxl_vld_o`, `pxl_o`, `pxl_row_o`, `pxl_col_o`, `pxl_eol_o`, `pxl_eof_o` all 0.
- Latency: the row handshake occurs in cycle t. `pxl_vld_o` rises at t+1 with column 0.
- With `pxl_rdy_i` held high:
  - one pixel per cycle;
  - W+1 cycles per row, including the `WAIT` handshake cycle when the next valid is already high;
  - H·(W+1) cycles per frame.
- After the end-of-line handshake in cycle t, `pxl_vld_o` = 0 and `rdy[row_idx+1]` = 1 in cycle t+1.
- Asserting `rst_n` low mid-row or mid-frame immediately forces the reset values. The partially drained row is discarded, and the next frame starts from row 0.

## Structure
- `RszPxlRow_t`, `FcRszPxlRow_t`, `FcRszPxlBuf_t`, `RSZ_IMG_WIDTH_IDX_W` and `RSZ_IMG_HEIGHT_IDX_W` come from `ImgRszPkg`.
- Add a packed pixel type `FcRszPxlFlat_t` (`PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W` bits) to the package.
- Single module with no sub-module. The FSM, the two counters and the row register are too small to split.

## Test plan
All scenarios use W = H = 8, one colour, 8-bit pixels.
- Reset: hold `rst_n` = 0, then release → `rdy_o` = 8'h01 and all other outputs 0. Pulse `rst_n` low asynchronously mid-cycle → outputs clear without waiting for a clock edge.
- Single row: row 0 = 0x10..0x17, `vld` = 8'h01, `pxl_rdy_i` = 1 → handshake cycle t; pixels 0x10..0x17 in cycles t+1..t+8 with col 0..7; `eol` only on 0x17; `rdy_o` = 8'h02 at t+9.
- Out-of-order: `vld` = 8'h08 only for 20 cycles → `rdy_o` stays 8'h01 and `pxl_vld_o` stays 0. Then `vld` = 8'h09 → row 0 drains first, then `rdy_o` = 8'h02 and nothing further (row 3 still waits its turn).
- Backpressure: `pxl_rdy_i` pattern 1,0,0,1,0,1… during a row → each pixel held stable while not ready; the sequence 0x10..0x17 arrives with no drops or duplicates.
- Full frame: all `vld` high, pixel value = row·16 + col, `pxl_rdy_i` = 1 → 64 pixels 0x00..0x77 in raster order; `eof` only on 0x77; 72 cycles total; `rdy_o` back to 8'h01 afterwards.
- Reset mid-drain: pulse `rst_n` low at row 2, col 3 → reset values; after release, row 0 is serviced first and its pixels come out intact.

Source files
------------

// File: rtl/ImgRszPkg.sv
// Shared resizer image types and geometry for the row-forwarding receive path.
package ImgRszPkg;

    localparam int RSZ_IMG_WIDTH_SIZE   = 8;
    localparam int RSZ_IMG_HEIGHT_SIZE  = 8;
    localparam int PXL_PRIM_COLOR_NUM   = 1;
    localparam int PXL_PRIM_COLOR_W     = 8;
    localparam int RSZ_IMG_WIDTH_IDX_W  = $clog2(RSZ_IMG_WIDTH_SIZE);
    localparam int RSZ_IMG_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE);
    localparam int PXL_FLAT_W           = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W;

    localparam logic [RSZ_IMG_WIDTH_IDX_W-1:0]  COL_LAST = RSZ_IMG_WIDTH_IDX_W'(RSZ_IMG_WIDTH_SIZE - 1);
    localparam logic [RSZ_IMG_HEIGHT_IDX_W-1:0] ROW_LAST = RSZ_IMG_HEIGHT_IDX_W'(RSZ_IMG_HEIGHT_SIZE - 1);

    typedef logic [PXL_PRIM_COLOR_W-1:0]                          PxlPrim_t;
    typedef PxlPrim_t [RSZ_IMG_WIDTH_SIZE-1:0]                    RszPxlRow_t;
    typedef logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0]  FcRszPxl_t;
    typedef FcRszPxl_t [RSZ_IMG_WIDTH_SIZE-1:0]                   FcRszPxlRow_t;
    typedef FcRszPxlRow_t [RSZ_IMG_HEIGHT_SIZE-1:0]               FcRszPxlBuf_t;
    typedef logic [PXL_FLAT_W-1:0]                                FcRszPxlFlat_t;

    typedef enum logic {
        ST_WAIT  = 1'b0,
        ST_DRAIN = 1'b1
    } DrainState_t;

    function automatic logic [RSZ_IMG_HEIGHT_SIZE-1:0] row_onehot(
        input logic [RSZ_IMG_HEIGHT_IDX_W-1:0] idx
    );
        row_onehot      = '0;
        row_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rsz_row_drain.sv
// Accepts resized rows in order over per-row valid/ready and replays each one
// as a raster-order pixel stream tagged with row, column, end-of-line and end-of-frame.
module rsz_row_drain
    import ImgRszPkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  FcRszPxlBuf_t                       fwd_rsz_pxl_i,
    input  logic [RSZ_IMG_HEIGHT_SIZE-1:0]     fwd_rsz_pxl_vld_i,
    output logic [RSZ_IMG_HEIGHT_SIZE-1:0]     fwd_rsz_pxl_rdy_o,
    output logic [PXL_FLAT_W-1:0]              pxl_o,
    output logic                               pxl_vld_o,
    input  logic                               pxl_rdy_i,
    output logic [RSZ_IMG_HEIGHT_IDX_W-1:0]    pxl_row_o,
    output logic [RSZ_IMG_WIDTH_IDX_W-1:0]     pxl_col_o,
    output logic                               pxl_eol_o,
    output logic                               pxl_eof_o
);

    DrainState_t                       r_state;
    DrainState_t                       w_state_nxt;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0]   r_row_idx;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0]   w_row_idx_nxt;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]    r_col_idx;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]    w_col_idx_nxt;
    FcRszPxlRow_t                      r_row_buf;
    logic                              w_row_take;
    logic                              w_eol;

    assign w_eol = (r_col_idx == COL_LAST);

    // Ready is decoded from state only, so upstream valid never loops back into ready.
    always_comb begin
        w_state_nxt       = r_state;
        w_row_idx_nxt     = r_row_idx;
        w_col_idx_nxt     = r_col_idx;
        w_row_take        = 1'b0;
        fwd_rsz_pxl_rdy_o = '0;
        pxl_vld_o         = 1'b0;
        case (r_state)
            ST_WAIT: begin
                fwd_rsz_pxl_rdy_o = row_onehot(r_row_idx);
                if (fwd_rsz_pxl_vld_i[r_row_idx]) begin
                    w_row_take    = 1'b1;
                    w_col_idx_nxt = '0;
                    w_state_nxt   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pxl_vld_o = 1'b1;
                if (pxl_rdy_i) begin
                    if (w_eol) begin
                        w_col_idx_nxt = '0;
                        w_row_idx_nxt = r_row_idx + RSZ_IMG_HEIGHT_IDX_W'(1);
                        w_state_nxt   = ST_WAIT;
                    end else begin
                        w_col_idx_nxt = r_col_idx + RSZ_IMG_WIDTH_IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_WAIT;
            r_row_idx <= '0;
            r_col_idx <= '0;
            r_row_buf <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_row_idx <= w_row_idx_nxt;
            r_col_idx <= w_col_idx_nxt;
            if (w_row_take) begin
                r_row_buf <= fwd_rsz_pxl_i[r_row_idx];
            end
        end
    end

    assign pxl_o     = r_row_buf[r_col_idx];
    assign pxl_row_o = r_row_idx;
    assign pxl_col_o = r_col_idx;
    assign pxl_eol_o = w_eol;
    assign pxl_eof_o = w_eol & (r_row_idx == ROW_LAST);

endmodule

// File: tb/tb_rsz_row_drain.sv
// Bench for rsz_row_drain: vector table, directed corner sequences and a
// randomized multi-frame run against a transaction-level stream model.
module tb_rsz_row_drain;
    import ImgRszPkg::*;

    localparam int W  = RSZ_IMG_WIDTH_SIZE;
    localparam int H  = RSZ_IMG_HEIGHT_SIZE;
    localparam int PW = PXL_FLAT_W;
    localparam int NF = 3;

    logic                              clk = 1'b0;
    logic                              rst_n = 1'b0;
    FcRszPxlBuf_t                      fwd_rsz_pxl_i;
    logic [H-1:0]                      fwd_rsz_pxl_vld_i;
    logic [H-1:0]                      fwd_rsz_pxl_rdy_o;
    logic [PW-1:0]                     pxl_o;
    logic                              pxl_vld_o;
    logic                              pxl_rdy_i;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0]   pxl_row_o;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]    pxl_col_o;
    logic                              pxl_eol_o;
    logic                              pxl_eof_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rsz_row_drain u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fwd_rsz_pxl_i     (fwd_rsz_pxl_i),
        .fwd_rsz_pxl_vld_i (fwd_rsz_pxl_vld_i),
        .fwd_rsz_pxl_rdy_o (fwd_rsz_pxl_rdy_o),
        .pxl_o             (pxl_o),
        .pxl_vld_o         (pxl_vld_o),
        .pxl_rdy_i         (pxl_rdy_i),
        .pxl_row_o         (pxl_row_o),
        .pxl_col_o         (pxl_col_o),
        .pxl_eol_o         (pxl_eol_o),
        .pxl_eof_o         (pxl_eof_o)
    );

    typedef struct {
        logic [H-1:0] vld;
        logic         prdy;
        logic         exp_vld;
        logic [H-1:0] exp_rdy;
        int           exp_row;
        int           exp_col;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] act_pix();
        return {pxl_vld_o, fwd_rsz_pxl_rdy_o, pxl_row_o, pxl_col_o, pxl_o, pxl_eol_o, pxl_eof_o};
    endfunction

    function automatic logic [63:0] exp_pix(input int r, input int c, input int v);
        logic eol;
        eol = (c == W - 1);
        return {1'b1, {H{1'b0}}, RSZ_IMG_HEIGHT_IDX_W'(r), RSZ_IMG_WIDTH_IDX_W'(c),
                PW'(v), eol, eol && (r == H - 1)};
    endfunction

    function automatic logic [63:0] exp_reset();
        return {1'b0, {{(H-1){1'b0}}, 1'b1}, {RSZ_IMG_HEIGHT_IDX_W{1'b0}},
                {RSZ_IMG_WIDTH_IDX_W{1'b0}}, {PW{1'b0}}, 1'b0, 1'b0};
    endfunction

    function automatic logic [63:0] act_idle();
        return {pxl_vld_o, fwd_rsz_pxl_rdy_o, pxl_eol_o, pxl_eof_o};
    endfunction

    function automatic logic [63:0] exp_idle(input int r);
        logic [H-1:0] oh;
        oh    = '0;
        oh[r] = 1'b1;
        return {1'b0, oh, 1'b0, 1'b0};
    endfunction

    task automatic fill(input int base);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                fwd_rsz_pxl_i[r][c] = PW'(base + r * 16 + c);
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        fwd_rsz_pxl_vld_i = '0;
        pxl_rdy_i         = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] frm [NF][H][W];

    initial begin
        logic [H-1:0] hs;
        int cyc;
        int n;
        int fr [H];
        int m_row, m_col, m_frame;
        bit m_drain, take, acc;

        // inputs before the edge -> outputs after it; row r pixel c = 0x10 + r*16 + c
        vt[0]  = '{8'h01, 1'b1, 1'b1, 8'h00, 0, 0};
        vt[1]  = '{8'h00, 1'b1, 1'b1, 8'h00, 0, 1};
        vt[2]  = '{8'h00, 1'b0, 1'b1, 8'h00, 0, 1};
        vt[3]  = '{8'h00, 1'b0, 1'b1, 8'h00, 0, 1};
        vt[4]  = '{8'h00, 1'b1, 1'b1, 8'h00, 0, 2};
        vt[5]  = '{8'h00, 1'b0, 1'b1, 8'h00, 0, 2};
        vt[6]  = '{8'h00, 1'b1, 1'b1, 8'h00, 0, 3};
        vt[7]  = '{8'h00, 1'b1, 1'b1, 8'h00, 0, 4};
        vt[8]  = '{8'h00, 1'b0, 1'b1, 8'h00, 0, 4};
        vt[9]  = '{8'h00, 1'b1, 1'b1, 8'h00, 0, 5};
        vt[10] = '{8'h00, 1'b1, 1'b1, 8'h00, 0, 6};
        vt[11] = '{8'h00, 1'b1, 1'b1, 8'h00, 0, 7};
        vt[12] = '{8'h00, 1'b0, 1'b1, 8'h00, 0, 7};
        vt[13] = '{8'h00, 1'b1, 1'b0, 8'h02, 0, 0};
        vt[14] = '{8'h08, 1'b1, 1'b0, 8'h02, 0, 0};
        vt[15] = '{8'h0A, 1'b1, 1'b1, 8'h00, 1, 0};

        fwd_rsz_pxl_i     = '0;
        fwd_rsz_pxl_vld_i = '0;
        pxl_rdy_i         = 1'b0;
        tick();
        chk("reset_hold", act_pix(), exp_reset());
        tick();
        rst_n = 1'b1;
        tick();
        chk("reset_release", act_pix(), exp_reset());

        fill(16);
        for (int i = 0; i < 16; i++) begin
            fwd_rsz_pxl_vld_i = vt[i].vld;
            pxl_rdy_i         = vt[i].prdy;
            tick();
            if (vt[i].exp_vld)
                chk($sformatf("vec%0d", i), act_pix(),
                    exp_pix(vt[i].exp_row, vt[i].exp_col, 16 + vt[i].exp_row * 16 + vt[i].exp_col));
            else
                chk($sformatf("vec%0d", i), act_idle(), {1'b0, vt[i].exp_rdy, 1'b0, 1'b0});
        end

        // asynchronous reset mid-cycle while row 1 drains
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", act_pix(), exp_reset());
        do_reset();

        fill(16);
        fwd_rsz_pxl_vld_i = 8'h08;
        pxl_rdy_i         = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("ooo_wait", act_idle(), exp_idle(0));
        end
        fwd_rsz_pxl_vld_i = 8'h09;
        tick();
        fwd_rsz_pxl_vld_i = 8'h08;
        for (int c = 0; c < W; c++) begin
            chk("ooo_row0", act_pix(), exp_pix(0, c, 16 + c));
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            chk("ooo_row3_waits", act_idle(), exp_idle(1));
            tick();
        end

        do_reset();
        fill(0);
        fwd_rsz_pxl_vld_i = '1;
        pxl_rdy_i         = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < H * W && cyc < 200) begin
            hs = fwd_rsz_pxl_rdy_o & fwd_rsz_pxl_vld_i;
            if (pxl_vld_o && pxl_rdy_i) begin
                chk("frame_pix", act_pix(), exp_pix(n / W, n % W, (n / W) * 16 + (n % W)));
                n++;
            end
            tick();
            cyc++;
            fwd_rsz_pxl_vld_i = fwd_rsz_pxl_vld_i & ~hs;
        end
        chk("frame_cycles", cyc, H * (W + 1));
        chk("frame_end_idle", act_idle(), exp_idle(0));

        do_reset();
        fill(0);
        fwd_rsz_pxl_vld_i = '1;
        pxl_rdy_i         = 1'b1;
        cyc = 0;
        while (!(pxl_vld_o && pxl_row_o == 2 && pxl_col_o == 3) && cyc < 100) begin
            hs = fwd_rsz_pxl_rdy_o & fwd_rsz_pxl_vld_i;
            tick();
            cyc++;
            fwd_rsz_pxl_vld_i = fwd_rsz_pxl_vld_i & ~hs;
        end
        chk("middrain_reached", cyc < 100, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("middrain_reset", act_pix(), exp_reset());
        tick();
        fwd_rsz_pxl_vld_i = '0;
        fill(128);
        rst_n = 1'b1;
        fwd_rsz_pxl_vld_i = '1;
        tick();
        fwd_rsz_pxl_vld_i[0] = 1'b0;
        for (int c = 0; c < W; c++) begin
            chk("after_reset_row0", act_pix(), exp_pix(0, c, 128 + c));
            tick();
        end
        chk("after_reset_idle", act_idle(), exp_idle(1));

        // randomized multi-frame run
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    frm[f][r][c] = 8'($urandom);
        do_reset();
        fwd_rsz_pxl_i = '0;
        for (int r = 0; r < H; r++) fr[r] = 0;
        m_row = 0; m_col = 0; m_frame = 0; m_drain = 0;
        cyc = 0;
        while (m_frame < NF && cyc < 6000) begin
            if (m_drain)
                chk("rand_pix", act_pix(), exp_pix(m_row, m_col, frm[m_frame][m_row][m_col]));
            else
                chk("rand_idle", act_idle(), exp_idle(m_row));
            for (int r = 0; r < H; r++) begin
                if (!fwd_rsz_pxl_vld_i[r] && fr[r] < NF && $urandom_range(3) == 0) begin
                    for (int c = 0; c < W; c++)
                        fwd_rsz_pxl_i[r][c] = frm[fr[r]][r][c];
                    fwd_rsz_pxl_vld_i[r] = 1'b1;
                end
            end
            pxl_rdy_i = ($urandom_range(2) != 0);
            take = !m_drain && fwd_rsz_pxl_vld_i[m_row];
            acc  = m_drain && pxl_rdy_i;
            tick();
            cyc++;
            if (take) begin
                fwd_rsz_pxl_vld_i[m_row] = 1'b0;
                fr[m_row]++;
                m_drain = 1;
                m_col   = 0;
            end else if (acc) begin
                if (m_col == W - 1) begin
                    m_drain = 0;
                    m_col   = 0;
                    m_row   = (m_row + 1) % H;
                    if (m_row == 0) m_frame++;
                end else begin
                    m_col++;
                end
            end
        end
        chk("rand_frames_done", m_frame, NF);
        chk("rand_end_idle", act_idle(), exp_idle(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
